// File: rtl/input_data_pkg.sv
// Shared processor I/O definitions: bus widths and input-unit state encodings.
// Imported by the input unit and its button debouncer.
package input_data_pkg;

  localparam int DEF_SW_WIDTH   = 18;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IN_IDLE         = 2'd0,
    IN_WAIT_PRESS   = 2'd1,
    IN_VALID        = 2'd2,
    IN_WAIT_RELEASE = 2'd3
  } in_state_e;

endpackage

// File: rtl/input_data_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and one-cycle
// press (debounced 1->0) / release (debounced 0->1) pulses.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta;
  logic             btn_sync;
  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchronizer chain only works because of that.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Button is active-low, so the idle (released) level is 1.
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      count    <= '0;
      level    <= 1'b1;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      press    <= 1'b0;
      released <= 1'b0;
      if (btn_sync == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count    <= '0;
        level    <= btn_sync;
        press    <= ~btn_sync;
        released <= btn_sync;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_data.sv
// Processor input unit: captures the synchronized switch word on a debounced
// button press while an IN instruction waits, with a valid/stall handshake.
module input_data
  import input_data_pkg::*;
#(
  parameter int SW_WIDTH        = DEF_SW_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SIGN_EXTEND     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  input_button,
  input  logic                  read_request,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  waiting,
  output logic                  ready_led
);

  localparam int EXT_W = DATA_WIDTH - SW_WIDTH;

  logic [SW_WIDTH-1:0]   sw_meta;
  logic [SW_WIDTH-1:0]   sw_sync;
  logic [DATA_WIDTH-1:0] sw_ext;
  logic                  btn_level;
  logic                  press_pulse;
  logic                  release_pulse;
  logic                  capture;
  in_state_e             state;
  in_state_e             next_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .button   (input_button),
    .level    (btn_level),
    .press    (press_pulse),
    .released (release_pulse)
  );

  assign sw_ext = {{EXT_W{(SIGN_EXTEND != 0) & sw_sync[SW_WIDTH-1]}}, sw_sync};

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    waiting    = 1'b0;
    ready_led  = 1'b0;
    case (state)
      IN_IDLE: begin
        // Presses seen here are deliberately dropped; nothing is buffered.
        if (read_request) next_state = IN_WAIT_PRESS;
      end
      IN_WAIT_PRESS: begin
        waiting   = 1'b1;
        ready_led = 1'b1;
        if (!read_request) begin
          next_state = IN_IDLE;
        end else if (press_pulse) begin
          capture    = 1'b1;
          next_state = IN_VALID;
        end
      end
      IN_VALID: begin
        // Consumed on this edge; a still-held button must be released first.
        if (read_request) next_state = btn_level ? IN_IDLE : IN_WAIT_RELEASE;
      end
      IN_WAIT_RELEASE: begin
        waiting = read_request;
        if (release_pulse) next_state = IN_IDLE;
      end
      default: next_state = IN_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IN_IDLE;
      data_out <= '0;
    end else begin
      state <= next_state;
      if (capture) data_out <= sw_ext;
    end
  end

  assign data_valid = (state == IN_VALID);

endmodule
